muldiv_seq: RTL

Multi-cycle integer multiply/divide sequencer for the EX stage. It executes MULT, MULTU, DIV and DIVU with iterative shift-add and restoring-divide algorithms, and holds the architectural HI/LO registers. A start/busy/done handshake stalls the pipeline while the single-cycle ALU continues to serve all other operations.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_addsub.sv | 27 ++
 rtl/muldiv_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared constants and types for the multiply/divide sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Default operand width; HI and LO are each this wide.
    localparam int DEFAULT_WIDTH = 32;

    // Operation encoding, sampled together with start.
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_addsub.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_addsub
// Brief    : (WIDTH+1)-bit adder/subtractor; sub=1 computes x - y.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_addsub
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0] x,
    input  logic [WIDTH:0] y,
    input  logic           sub,
    output logic [WIDTH:0] sum
);

    logic [WIDTH:0] w_y_inv;

    // Two's-complement subtract: invert y and inject the carry-in.
    always_comb begin
        w_y_inv = y ^ {(WIDTH + 1){sub}};
        sum     = x + w_y_inv + {{WIDTH{1'b0}}, sub};
    end

endmodule : muldiv_addsub
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO
//            registers, with start/busy/done handshake and flush.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_m;      // multiplicand / divisor
    logic [WIDTH-1:0] r_l;      // multiplier -> low product, dividend -> quotient
    logic [WIDTH-1:0] r_acc;    // upper product P / remainder R
    logic [1:0]       r_op;
    logic             r_sa;
    logic             r_sb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_dbz_start;
    logic             w_mt_ok;
    logic             w_is_div;
    logic             w_is_signed;
    logic [WIDTH:0]   w_hx;
    logic [WIDTH:0]   w_hy;
    logic             w_hsub;
    logic [WIDTH:0]   w_hi_sum;
    logic [WIDTH:0]   w_lo_sum;
    logic             w_l_nonzero;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_is_div    = r_op[1];
    assign w_is_signed = r_op[0];
    // Borrow out of 0 - L is set exactly when L is non-zero.
    assign w_l_nonzero = w_lo_sum[WIDTH];

    // Main adder: RUN iteration, operand magnitude of b in PREP, upper/remainder negation in FIX.
    muldiv_addsub #(.WIDTH(WIDTH)) u_addsub_hi (
        .x   (w_hx),
        .y   (w_hy),
        .sub (w_hsub),
        .sum (w_hi_sum)
    );

    // Negator for r_l: magnitude of a in PREP, low product / quotient negation in FIX.
    muldiv_addsub #(.WIDTH(WIDTH)) u_addsub_lo (
        .x   ({(WIDTH + 1){1'b0}}),
        .y   ({1'b0, r_l}),
        .sub (1'b1),
        .sum (w_lo_sum)
    );

    // Next-state and handshake decode; flush overrides everything.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_dbz_start = 1'b0;
        w_mt_ok     = !r_busy && !flush;
        if (flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_accept = 1'b1;
                        if (op[1] && (b == '0)) begin
                            w_dbz_start = 1'b1;
                            w_next      = ST_DONE;
                        end else begin
                            w_next = ST_PREP;
                        end
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
                ST_PREP: w_next = ST_RUN;
                ST_RUN:  w_next = (r_cnt == LAST_ITER) ? ST_FIX : ST_RUN;
                ST_FIX:  w_next = ST_DONE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // State register with registered busy/done derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_PREP) || (w_next == ST_RUN) || (w_next == ST_FIX);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Adder operand selection per state and operation.
    always_comb begin
        w_hx   = '0;
        w_hy   = {1'b0, r_m};
        w_hsub = 1'b1;
        case (r_state)
            ST_RUN: begin
                if (w_is_div) begin
                    w_hx   = {r_acc, r_l[WIDTH-1]};
                    w_hy   = {1'b0, r_m};
                    w_hsub = 1'b1;
                end else begin
                    w_hx   = {1'b0, r_acc};
                    w_hy   = r_l[0] ? {1'b0, r_m} : '0;
                    w_hsub = 1'b0;
                end
            end
            ST_FIX: begin
                if (w_is_div) begin
                    w_hx   = '0;
                    w_hy   = {1'b0, r_acc};
                    w_hsub = 1'b1;
                end else begin
                    // Upper half of a 2*WIDTH negate: ~P plus carry from the low half.
                    w_hx   = {1'b0, ~r_acc};
                    w_hy   = {{WIDTH{1'b0}}, !w_l_nonzero};
                    w_hsub = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Final sign correction of product or quotient/remainder.
    always_comb begin
        w_res_hi = r_acc;
        w_res_lo = r_l;
        if (w_is_signed) begin
            if (w_is_div) begin
                if (r_sa ^ r_sb) w_res_lo = w_lo_sum[WIDTH-1:0];
                if (r_sa)        w_res_hi = w_hi_sum[WIDTH-1:0];
            end else if (r_sa ^ r_sb) begin
                w_res_hi = w_hi_sum[WIDTH-1:0];
                w_res_lo = w_lo_sum[WIDTH-1:0];
            end
        end
    end

    // Operand capture, magnitude preparation and the per-cycle iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m   <= '0;
            r_l   <= '0;
            r_acc <= '0;
            r_op  <= OP_MULTU;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept && !w_dbz_start) begin
                        r_l  <= a;
                        r_m  <= b;
                        r_op <= op;
                    end
                end
                ST_PREP: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    if (w_is_signed) begin
                        r_sa <= r_l[WIDTH-1];
                        r_sb <= r_m[WIDTH-1];
                        if (r_l[WIDTH-1]) r_l <= w_lo_sum[WIDTH-1:0];
                        if (r_m[WIDTH-1]) r_m <= w_hi_sum[WIDTH-1:0];
                    end else begin
                        r_sa <= 1'b0;
                        r_sb <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_is_div) begin
                        if (!w_hi_sum[WIDTH]) begin
                            r_acc <= w_hi_sum[WIDTH-1:0];
                            r_l   <= {r_l[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc <= {r_acc[WIDTH-2:0], r_l[WIDTH-1]};
                            r_l   <= {r_l[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc <= w_hi_sum[WIDTH:1];
                        r_l   <= {w_hi_sum[0], r_l[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Architectural HI/LO and divide-by-zero flag; an op result overrides an MT write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_dbz <= 1'b0;
        end else begin
            if (w_mt_ok && mt_hi) r_hi <= mt_data;
            if (w_mt_ok && mt_lo) r_lo <= mt_data;
            if (w_dbz_start) begin
                r_hi  <= a;
                r_lo  <= '1;
                r_dbz <= 1'b1;
            end else if ((r_state == ST_FIX) && !flush) begin
                r_hi  <= w_res_hi;
                r_lo  <= w_res_lo;
                r_dbz <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dbz  = r_dbz;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule : muldiv_seq
`default_nettype wire
